// File: rtl/tx_arb_pkg.sv
// Shared definitions for the tx_frame_arbiter slice: FSM state encoding,
// byte width and a pointer-width helper.
package tx_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_frame_arbiter_if.sv
// Requester/uart_tx side bundle of tx_frame_arbiter.
// slave: arbiter view; master: requesters plus uart_tx view.
interface tx_frame_arbiter_if import tx_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 3
);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [BYTE_W*NUM_REQ-1:0] req_byte_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        grant_o;
  logic [BYTE_W-1:0]         sbyte_o;
  logic                      send_o;
  logic                      busy_i;
  logic                      frame_done_o;
  logic                      timeout_o;

  modport slave (
    input  req_valid_i, req_byte_i, req_last_i, busy_i,
    output req_ready_o, grant_o, sbyte_o, send_o, frame_done_o, timeout_o
  );

  modport master (
    output req_valid_i, req_byte_i, req_last_i, busy_i,
    input  req_ready_o, grant_o, sbyte_o, send_o, frame_done_o, timeout_o
  );

endinterface

// File: rtl/tx_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first requester
// found searching upward from the index after prev, wrapping to 0.
module rr_pick import tx_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [idx_w(NUM_REQ)-1:0] prev,
  output logic [NUM_REQ-1:0]        grant
);

  localparam int unsigned PTR_W = idx_w(NUM_REQ);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan NUM_REQ positions starting just after prev; first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((32'(prev) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one uart_tx from NUM_REQ byte
// requesters. Optional starvation watchdog: define TX_ARB_TIMEOUT_EN.
module tx_frame_arbiter import tx_arb_pkg::*; #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic             clk_i,
  input logic             rstn_i,
  tx_frame_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = idx_w(NUM_REQ);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("tx_frame_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   prev_q, prev_d;
  logic [BYTE_W-1:0]  sbyte_q, sbyte_d;
  logic               last_q, last_d;

  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] ready;
  logic [PTR_W-1:0]   owner_idx;
  logic [BYTE_W-1:0]  sel_byte;
  logic               sel_last;
  logic               owner_valid;
  logic               send;
  logic               done;
  logic               tmo;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (bus.req_valid_i),
    .prev  (prev_q),
    .grant (pick)
  );

  // Decode the one-hot owner into an index plus its byte/last/valid.
  always_comb begin
    owner_idx = '0;
    sel_byte  = '0;
    sel_last  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        owner_idx = PTR_W'(k);
      end
      sel_byte = sel_byte | ({BYTE_W{grant_q[k]}} & bus.req_byte_i[BYTE_W*k +: BYTE_W]);
      sel_last = sel_last | (grant_q[k] & bus.req_last_i[k]);
    end
    owner_valid = |(grant_q & bus.req_valid_i);
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prev_d  = prev_q;
    sbyte_d = sbyte_q;
    last_d  = last_q;
    ready   = '0;
    send    = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    cnt_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid_i) begin
          grant_d = pick;
          state_d = FETCH;
        end
      end
      FETCH: begin
        ready = grant_q & bus.req_valid_i & {NUM_REQ{~bus.busy_i}};
        if (|ready) begin
          sbyte_d = sel_byte;
          last_d  = sel_last;
          state_d = SEND;
        end
`ifdef TX_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          tmo     = 1'b1;
          grant_d = '0;
          prev_d  = owner_idx;
          state_d = IDLE;
        end else if (!owner_valid) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
`endif
      end
      SEND: begin
        send    = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.busy_i) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.busy_i) begin
          if (last_q) begin
            done    = 1'b1;
            grant_d = '0;
            prev_d  = owner_idx;
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, round-robin pointer and latched byte registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      grant_q <= '0;
      prev_q  <= PTR_W'(NUM_REQ - 1);
      sbyte_q <= '0;
      last_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      prev_q  <= prev_d;
      sbyte_q <= sbyte_d;
      last_q  <= last_d;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  // Starvation counter: consecutive FETCH cycles with owner valid low.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.req_ready_o  = ready;
  assign bus.grant_o      = grant_q;
  assign bus.sbyte_o      = sbyte_q;
  assign bus.send_o       = send;
  assign bus.frame_done_o = done;
`ifdef TX_ARB_TIMEOUT_EN
  assign bus.timeout_o    = tmo;
`else
  assign bus.timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter with requester queues and a uart_tx
// busy model. Covers TX_ARB_TIMEOUT_EN defined or undefined.
module tb_tx_frame_arbiter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tx_frame_arbiter_if #(.NUM_REQ(3)) bus ();

  tx_frame_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [2:0] g;
    logic [7:0] b;
    int         c;
  } ev_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_len = 4;
  int busy_cnt = 0;
  int done_cnt = 0;
  int tmo_cnt = 0;
  int tmo_cyc = 0;
  logic [2:0] pend = '0;
  logic send_pend = 1'b0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  ev_t log_q[$];
  logic [7:0] exp_b[6];
  logic [2:0] exp_g[6];

  // Requesters pop on acceptance; uart model stretches busy after send.
  always @(negedge clk) begin
    if (!rstn) begin
      pend      = '0;
      send_pend = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (pend[0] && q0.size() > 0) void'(q0.pop_front());
      if (pend[1] && q1.size() > 0) void'(q1.pop_front());
      if (pend[2] && q2.size() > 0) void'(q2.pop_front());
      if (send_pend) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
    end
    bus.busy_i = (busy_cnt != 0);
    bus.req_valid_i[0] = (q0.size() > 0);
    bus.req_valid_i[1] = (q1.size() > 0);
    bus.req_valid_i[2] = (q2.size() > 0);
    bus.req_byte_i[7:0]   = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    bus.req_byte_i[15:8]  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    bus.req_byte_i[23:16] = (q2.size() > 0) ? q2[0][7:0] : 8'h00;
    bus.req_last_i[0] = (q0.size() > 0) ? q0[0][8] : 1'b0;
    bus.req_last_i[1] = (q1.size() > 0) ? q1[0][8] : 1'b0;
    bus.req_last_i[2] = (q2.size() > 0) ? q2[0][8] : 1'b0;
    #2;
    cyc++;
    pend      = bus.req_ready_o;
    send_pend = bus.send_o;
    if (bus.send_o) log_q.push_back('{g: bus.grant_o, b: bus.sbyte_o, c: cyc});
    if (bus.frame_done_o) done_cnt++;
    if (bus.timeout_o) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_sends(input int n, input int budget, input string tag);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      at_sample();
      k++;
    end
    chk(tag, log_q.size(), n);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      at_sample();
      k++;
    end
    chk(tag, done_cnt, n);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    log_q.delete();
    done_cnt = 0;
    tmo_cnt  = 0;
    step(2);
    rstn = 1'b1;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int bad;

    // Reset values
    step(3);
    chk("rst_grant", bus.grant_o, 3'b000);
    chk("rst_ready", bus.req_ready_o, 3'b000);
    chk("rst_send", bus.send_o, 1'b0);
    chk("rst_done", bus.frame_done_o, 1'b0);
    chk("rst_timeout", bus.timeout_o, 1'b0);
    chk("rst_sbyte", bus.sbyte_o, 8'h00);
    rstn = 1'b1;
    step(1);

    // Single frame A5, 3C from req0; send three cycles after first valid
    q0.push_back({1'b0, 8'hA5});
    q0.push_back({1'b1, 8'h3C});
    at_sample();
    chk("t1_idle_grant", bus.grant_o, 3'b000);
    at_sample();
    chk("t1_fetch_grant", bus.grant_o, 3'b001);
    chk("t1_fetch_ready", bus.req_ready_o, 3'b001);
    at_sample();
    chk("t1_send", bus.send_o, 1'b1);
    chk("t1_sbyte0", bus.sbyte_o, 8'hA5);
    at_sample();
    chk("t1_send_one_cycle", bus.send_o, 1'b0);
    wait_sends(2, 40, "t1_sends");
    chk("t1_byte0", log_q[0].b, 8'hA5);
    chk("t1_byte1", log_q[1].b, 8'h3C);
    chk("t1_grant1", log_q[1].g, 3'b001);
    wait_done(1, 20, "t1_done");
    at_sample();
    chk("t1_grant_clear", bus.grant_o, 3'b000);
    repeat (5) at_sample();
    chk("t1_no_extra_send", log_q.size(), 2);
    chk("t1_one_done", done_cnt, 1);

    // Contention req0 vs req2 from reset: whole frames, no interleave
    do_reset();
    q0.push_back({1'b0, 8'h11});
    q0.push_back({1'b1, 8'h12});
    q2.push_back({1'b0, 8'h21});
    q2.push_back({1'b1, 8'h22});
    wait_sends(4, 80, "t2_sends");
    exp_b[0:3] = '{8'h11, 8'h12, 8'h21, 8'h22};
    exp_g[0:3] = '{3'b001, 3'b001, 3'b100, 3'b100};
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) begin
        chk($sformatf("t2_byte%0d", i), log_q[i].b, exp_b[i]);
        chk($sformatf("t2_grant%0d", i), log_q[i].g, exp_g[i]);
      end
    end
    wait_done(2, 20, "t2_done");

    // Fairness: three requesters, 1-byte frames, continuously valid
    step(3);
    log_q.delete();
    q0.push_back({1'b1, 8'hA0});
    q0.push_back({1'b1, 8'hA1});
    q1.push_back({1'b1, 8'hB0});
    q1.push_back({1'b1, 8'hB1});
    q2.push_back({1'b1, 8'hC0});
    q2.push_back({1'b1, 8'hC1});
    wait_sends(6, 120, "t3_sends");
    exp_b = '{8'hA0, 8'hB0, 8'hC0, 8'hA1, 8'hB1, 8'hC1};
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        chk($sformatf("t3_grant%0d", i), log_q[i].g, exp_g[i]);
        chk($sformatf("t3_byte%0d", i), log_q[i].b, exp_b[i]);
      end
    end
    step(10);

    // Busy stretch: 50 busy cycles block the next fetch
    log_q.delete();
    done_cnt = 0;
    busy_len = 50;
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b1, 8'h42});
    wait_sends(1, 20, "t4_first_send");
    bad = 0;
    repeat (40) begin
      at_sample();
      if (bus.req_ready_o !== 3'b000) bad++;
    end
    chk("t4_ready_while_busy", bad, 0);
    chk("t4_no_second_send", log_q.size(), 1);
    wait_sends(2, 80, "t4_second_send");
    if (log_q.size() == 2) begin
      chk("t4_send_gap", log_q[1].c - log_q[0].c, 53);
      chk("t4_byte1", log_q[1].b, 8'h42);
    end
    wait_done(1, 80, "t4_done");
    busy_len = 4;
    step(3);

    // Starvation: req1 goes idle mid-frame while req2 waits
    log_q.delete();
    q1.push_back({1'b0, 8'h51});
    q2.push_back({1'b1, 8'h61});
    wait_sends(1, 20, "t5_first_send");
    chk("t5_owner", log_q[0].g, 3'b010);
`ifdef TX_ARB_TIMEOUT_EN
    wait_sends(2, 60, "t5_second_send");
    chk("t5_timeout_count", tmo_cnt, 1);
    chk("t5_timeout_time", tmo_cyc - log_q[0].c, 22);
    if (log_q.size() == 2) begin
      chk("t5_next_grant", log_q[1].g, 3'b100);
      chk("t5_next_byte", log_q[1].b, 8'h61);
    end
`else
    repeat (60) at_sample();
    chk("t5_grant_held", bus.grant_o, 3'b010);
    chk("t5_no_other_send", log_q.size(), 1);
    chk("t5_no_timeout", tmo_cnt, 0);
`endif

    // Reset in WAIT_DONE aborts the frame; req0 first afterwards
    do_reset();
    q1.push_back({1'b0, 8'h71});
    q1.push_back({1'b1, 8'h72});
    wait_sends(1, 20, "t6_first_send");
    at_sample();
    at_sample();
    rstn = 1'b0;
    #1;
    chk("t6_rst_grant", bus.grant_o, 3'b000);
    chk("t6_rst_ready", bus.req_ready_o, 3'b000);
    chk("t6_rst_send", bus.send_o, 1'b0);
    chk("t6_rst_done", bus.frame_done_o, 1'b0);
    chk("t6_rst_timeout", bus.timeout_o, 1'b0);
    chk("t6_rst_sbyte", bus.sbyte_o, 8'h00);
    chk("t6_no_done", done_cnt, 0);
    q0.delete();
    q1.delete();
    q2.delete();
    log_q.delete();
    step(2);
    rstn = 1'b1;
    step(1);
    q0.push_back({1'b1, 8'h81});
    q1.push_back({1'b1, 8'h91});
    wait_sends(2, 40, "t6_sends");
    if (log_q.size() == 2) begin
      chk("t6_first_grant", log_q[0].g, 3'b001);
      chk("t6_first_byte", log_q[0].b, 8'h81);
      chk("t6_second_grant", log_q[1].g, 3'b010);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of frame requesters sharing one uart_tx.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: owner starvation limit in clk_i cycles; used only under the macro in REQ-028.
REQ-003 SHALL have ports:
- clk_i, input, 1: single clock.
- rstn_i, input, 1: reset, asynchronous, active-low.
- req_valid_i, input, NUM_REQ: requester k presents a byte.
- req_byte_i, input, 8*NUM_REQ: byte of requester k is at bits [8k+7:8k].
- req_last_i, input, NUM_REQ: presented byte is the last byte of its frame.
- req_ready_o, output, NUM_REQ: byte of requester k is accepted this cycle.
- grant_o, output, NUM_REQ: one-hot current frame owner; all zero when no owner.
- sbyte_o, output, 8: byte to uart_tx sbyte_i.
- send_o, output, 1: one-cycle start pulse to uart_tx send_i.
- busy_i, input, 1: from uart_tx busy_o.
- frame_done_o, output, 1: one-cycle pulse after the last byte of a frame completes.
- timeout_o, output, 1: one-cycle pulse when an owner is dropped for starvation.

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, SEND, WAIT_ACK and WAIT_DONE.
REQ-005 IDLE: if any req_valid_i bit is 1, SHALL pick the owner round-robin, set grant_o one-hot on the next edge and go to FETCH; otherwise SHALL stay in IDLE with grant_o=0.
REQ-006 Round-robin search SHALL start at the index after the previous owner and wrap from NUM_REQ-1 to 0; after reset the search starts at index 0.
REQ-007 Arbitration SHALL be frame-granular: grant_o SHALL NOT change until the owner's last byte completes or a timeout occurs.
REQ-008 FETCH: req_ready_o[g] SHALL be combinationally high when the owner's req_valid_i[g]=1 and busy_i=0; all other req_ready_o bits SHALL be 0.
REQ-009 On the edge where req_ready_o[g]=1, the block SHALL latch req_byte_i slice g into sbyte_o, latch req_last_i[g], and go to SEND.
REQ-010 SEND: send_o SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_ACK.
REQ-011 WAIT_ACK: the FSM SHALL go to WAIT_DONE when busy_i=1; uart_tx asserts busy_i the cycle after send_i.
REQ-012 WAIT_DONE: when busy_i=0 the FSM SHALL do one of the following:
- latched last=1: pulse frame_done_o, clear grant_o, record the owner as previous owner, go to IDLE.
- latched last=0: go to FETCH.
REQ-013 sbyte_o SHALL hold its value from the latch edge until the next latch.
REQ-014 If an owner deasserts req_valid_i mid-frame, the block SHALL remain in FETCH holding the grant.
REQ-015 Requests from non-owners SHALL be ignored until the FSM returns to IDLE; no request is lost while valid is held.
REQ-016 Minimum spacing: one byte per uart_tx frame; from IDLE with valid, send_o SHALL rise 3 cycles after the first valid edge (IDLE, FETCH, SEND).
REQ-017 Single requester with back-to-back frames SHALL pass through IDLE for one cycle between frames and be re-granted.

Reset
REQ-018 When rstn_i=0, the FSM SHALL go asynchronously to IDLE.
REQ-019 During reset, grant_o, req_ready_o, send_o, frame_done_o and timeout_o SHALL be 0, and sbyte_o SHALL be 8'h00.
REQ-020 During reset, the previous-owner pointer SHALL be NUM_REQ-1 (first search starts at 0) and the timeout counter SHALL be 0.
REQ-021 Reset mid-frame SHALL abort the frame without frame_done_o; uart_tx resets from the same rstn_i.

Configuration
REQ-022 Macro TX_ARB_TIMEOUT_EN SHALL select the starvation watchdog.
REQ-023 With TX_ARB_TIMEOUT_EN defined, a counter SHALL count consecutive FETCH cycles with req_valid_i[g]=0.
REQ-024 With TX_ARB_TIMEOUT_EN defined, the counter SHALL clear on any accepted byte and on leaving FETCH.
REQ-025 With TX_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL pulse timeout_o, clear grant_o, advance the pointer past the owner and go to IDLE.
REQ-026 With TX_ARB_TIMEOUT_EN defined, the counter width SHALL be $clog2(TIMEOUT_CYCLES+1).
REQ-027 Without TX_ARB_TIMEOUT_EN, no counter SHALL exist, timeout_o SHALL be tied 0, and FETCH waits indefinitely.
REQ-028 TIMEOUT_CYCLES SHALL be ignored unless TX_ARB_TIMEOUT_EN is defined.

Structure
REQ-029 Shared package tx_arb_pkg SHALL hold the FSM state encoding (3 bits) and the byte width constant 8.
REQ-030 A sub-module rr_pick SHALL compute the one-hot round-robin grant from the request vector and the previous-owner pointer, combinationally.
REQ-031 The sub-module SHALL be parameterised by NUM_REQ.

Verification
REQ-032 Single frame: req0 sends 8'hA5, 8'h3C (last) -> send_o pulses twice, sbyte_o=A5 then 3C, one frame_done_o, grant_o 001 then 000.
REQ-033 Contention: req0 and req2 both valid with 2-byte frames from reset -> req0's frame is sent fully, then req2's; bytes never interleave.
REQ-034 Fairness: req0, req1 and req2 continuously valid with 1-byte frames -> grant order 0,1,2,0,1,2.
REQ-035 Busy stretch: busy_i held high 50 cycles after send -> no req_ready_o and no second send_o until busy_i falls.
REQ-036 Starvation: with TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, req1 drops valid mid-frame -> timeout_o pulses after 16 FETCH cycles and req2 is granted next. Without the macro, grant holds at 010.
REQ-037 Reset mid-frame: rstn_i low during WAIT_DONE -> all outputs zero immediately; after release, req0 is granted first.
